// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: measures hs/vs timing, acquires lock after a run of
// good frames and emits active-pixel coordinates plus qualified RGB data.
// Every output is registered and reflects the input sample of the same edge.
module vga_sync_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int H_ACT_START = 144,
    parameter int H_ACTIVE    = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_ACT_START = 35,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic [11:0] pixel_data,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_de,
    output logic [11:0] pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic        lock_err,
    output logic [10:0] line_len,
    output logic [10:0] frame_lines
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [10:0] H_MAX   = 11'd2047;
    localparam logic [10:0] H_TOT_W = 11'(H_TOTAL);
    localparam logic [10:0] V_TOT_W = 11'(V_TOTAL);
    localparam logic [10:0] H_LO    = 11'(H_ACT_START);
    localparam logic [10:0] H_HI    = 11'(H_ACT_START + H_ACTIVE);
    localparam logic [10:0] V_LO    = 11'(V_ACT_START);
    localparam logic [10:0] V_HI    = 11'(V_ACT_START + V_ACTIVE);
    localparam logic [2:0]  LOCK_W  = 3'(LOCK_FRAMES);

    // Saturating 11-bit increment shared by position, line and line-count counters.
    function automatic logic [10:0] sat_inc(input logic [10:0] val, input logic inc);
        if (inc && (val != H_MAX)) begin
            return val + 11'd1;
        end else begin
            return val;
        end
    endfunction

    state_t      state_r;
    logic        hs_prev_r;
    logic        vs_prev_r;
    logic [10:0] h_r;
    logic [10:0] v_r;
    logic        hs_seen_r;
    logic [10:0] line_cnt_r;
    logic        frame_bad_r;
    logic [2:0]  good_cnt_r;

    logic        hs_rise_s;
    logic        vs_rise_s;
    logic [10:0] h_next_s;
    logic [10:0] v_next_s;
    logic        timeout_s;
    logic        bad_line_s;
    logic        bad_frame_s;
    logic        bad_s;
    logic        enter_lock_s;
    logic        lock_next_s;
    logic        h_active_s;
    logic        v_active_s;
    logic        de_next_s;

    // Decode edges, next raster position and the good/bad events of this sample.
    always_comb begin
        hs_rise_s = vga_hs & ~hs_prev_r;
        vs_rise_s = vga_vs & ~vs_prev_r;

        if (hs_rise_s) begin
            h_next_s = 11'd0;
        end else begin
            h_next_s = sat_inc(h_r, 1'b1);
        end

        // A vs rise wins over a simultaneous hs rise so the new frame starts on line 0.
        if (vs_rise_s) begin
            v_next_s = 11'd0;
        end else begin
            v_next_s = sat_inc(v_r, hs_rise_s);
        end

        // Only the transition into saturation is an event, not every saturated cycle.
        timeout_s    = (h_next_s == H_MAX) && (h_r != H_MAX);
        bad_line_s   = hs_rise_s && hs_seen_r && ((h_r + 11'd1) != H_TOT_W);
        // The first vs rise seen in SEARCH has no complete frame behind it.
        bad_frame_s  = vs_rise_s && (state_r != ST_SEARCH) && (line_cnt_r != V_TOT_W);
        bad_s        = bad_line_s | bad_frame_s | timeout_s;

        enter_lock_s = (state_r == ST_VERIFY) && vs_rise_s && !bad_s && !frame_bad_r
                       && ((good_cnt_r + 3'd1) == LOCK_W);
        lock_next_s  = enter_lock_s || ((state_r == ST_LOCKED) && !bad_s);

        h_active_s   = (h_next_s >= H_LO) && (h_next_s < H_HI);
        v_active_s   = (v_next_s >= V_LO) && (v_next_s < V_HI);
        de_next_s    = lock_next_s && h_active_s && v_active_s;
    end

    // Raster counters, edge history and line/frame period measurement.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_prev_r   <= 1'b0;
            vs_prev_r   <= 1'b0;
            h_r         <= 11'd0;
            v_r         <= 11'd0;
            hs_seen_r   <= 1'b0;
            line_cnt_r  <= 11'd0;
            frame_bad_r <= 1'b0;
            line_len    <= 11'd0;
            frame_lines <= 11'd0;
        end else begin
            hs_prev_r <= vga_hs;
            vs_prev_r <= vga_vs;
            h_r       <= h_next_s;
            v_r       <= v_next_s;

            if (timeout_s) begin
                hs_seen_r <= 1'b0;
            end else if (hs_rise_s) begin
                hs_seen_r <= 1'b1;
            end else begin
                hs_seen_r <= hs_seen_r;
            end

            // An hs rise coinciding with a vs rise belongs to the new frame.
            if (vs_rise_s) begin
                line_cnt_r <= {10'd0, hs_rise_s};
            end else begin
                line_cnt_r <= sat_inc(line_cnt_r, hs_rise_s);
            end

            if (vs_rise_s) begin
                frame_bad_r <= 1'b0;
            end else begin
                frame_bad_r <= frame_bad_r | bad_line_s;
            end

            if (hs_rise_s && hs_seen_r) begin
                line_len <= h_r + 11'd1;
            end else begin
                line_len <= line_len;
            end

            if (vs_rise_s) begin
                frame_lines <= line_cnt_r;
            end else begin
                frame_lines <= frame_lines;
            end
        end
    end

    // Lock acquisition FSM with registered locked/lock_err/frame_start.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_SEARCH;
            good_cnt_r  <= 3'd0;
            locked      <= 1'b0;
            lock_err    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            case (state_r)
                ST_SEARCH: begin
                    locked      <= 1'b0;
                    lock_err    <= 1'b0;
                    frame_start <= 1'b0;
                    good_cnt_r  <= 3'd0;
                    if (vs_rise_s) begin
                        state_r <= ST_VERIFY;
                    end else begin
                        state_r <= ST_SEARCH;
                    end
                end
                ST_VERIFY: begin
                    frame_start <= 1'b0;
                    if (timeout_s) begin
                        state_r    <= ST_SEARCH;
                        good_cnt_r <= 3'd0;
                        locked     <= 1'b0;
                        lock_err   <= 1'b1;
                    end else if (bad_s) begin
                        state_r    <= ST_VERIFY;
                        good_cnt_r <= 3'd0;
                        locked     <= 1'b0;
                        lock_err   <= 1'b1;
                    end else if (enter_lock_s) begin
                        state_r    <= ST_LOCKED;
                        good_cnt_r <= 3'd0;
                        locked     <= 1'b1;
                        lock_err   <= 1'b0;
                    end else if (vs_rise_s && !frame_bad_r) begin
                        state_r    <= ST_VERIFY;
                        good_cnt_r <= good_cnt_r + 3'd1;
                        locked     <= 1'b0;
                        lock_err   <= 1'b0;
                    end else if (vs_rise_s) begin
                        state_r    <= ST_VERIFY;
                        good_cnt_r <= 3'd0;
                        locked     <= 1'b0;
                        lock_err   <= 1'b0;
                    end else begin
                        state_r    <= ST_VERIFY;
                        good_cnt_r <= good_cnt_r;
                        locked     <= 1'b0;
                        lock_err   <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    good_cnt_r <= 3'd0;
                    if (bad_s) begin
                        state_r     <= ST_SEARCH;
                        locked      <= 1'b0;
                        lock_err    <= 1'b1;
                        frame_start <= 1'b0;
                    end else begin
                        state_r     <= ST_LOCKED;
                        locked      <= 1'b1;
                        lock_err    <= 1'b0;
                        frame_start <= vs_rise_s;
                    end
                end
                default: begin
                    state_r     <= ST_SEARCH;
                    good_cnt_r  <= 3'd0;
                    locked      <= 1'b0;
                    lock_err    <= 1'b0;
                    frame_start <= 1'b0;
                end
            endcase
        end
    end

    // Active-pixel qualifier, coordinates and gated RGB.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_de  <= 1'b0;
            pix_x   <= 10'd0;
            pix_y   <= 10'd0;
            pix_rgb <= 12'd0;
        end else begin
            pix_de <= de_next_s;
            if (de_next_s) begin
                pix_x   <= 10'(h_next_s - H_LO);
                pix_y   <= 10'(v_next_s - V_LO);
                pix_rgb <= pixel_data;
            end else begin
                pix_x   <= 10'd0;
                pix_y   <= 10'd0;
                pix_rgb <= 12'd0;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Self-checking bench for vga_sync_decoder using a scaled-down raster
// (32 clocks x 12 lines) so that several lock/unlock cycles fit in a short run.
module tb_vga_sync_decoder;

    localparam int HT   = 32;
    localparam int HAS  = 8;
    localparam int HA   = 16;
    localparam int VT   = 12;
    localparam int VAS  = 3;
    localparam int VA   = 6;
    localparam int LF   = 2;
    localparam int HS_W = 4;
    localparam int NV   = 8;

    logic        sys_clk;
    logic        rst_n;
    logic        vga_hs;
    logic        vga_vs;
    logic [11:0] pixel_data;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        pix_de;
    logic [11:0] pix_rgb;
    logic        frame_start;
    logic        locked;
    logic        lock_err;
    logic [10:0] line_len;
    logic [10:0] frame_lines;

    vga_sync_decoder #(
        .H_TOTAL(HT), .H_ACT_START(HAS), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_ACT_START(VAS), .V_ACTIVE(VA),
        .LOCK_FRAMES(LF)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .pixel_data(pixel_data), .pix_x(pix_x), .pix_y(pix_y), .pix_de(pix_de),
        .pix_rgb(pix_rgb), .frame_start(frame_start), .locked(locked),
        .lock_err(lock_err), .line_len(line_len), .frame_lines(frame_lines)
    );

    typedef struct {
        int          line;
        int          h;
        logic [11:0] rgb;
        int          exp_de;
        int          exp_x;
        int          exp_y;
        int          exp_rgb;
    } vec_t;

    vec_t tbl [NV];

    int n_checks;
    int n_fail;
    int samp;
    int lock_samp;
    int err_cnt;
    int err_samp;
    int fs_cnt;
    int fs_samp;
    int de_cnt;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        samp      = 0;
        lock_samp = -1;
        err_cnt   = 0;
        err_samp  = -1;
        fs_cnt    = 0;
        fs_samp   = -1;
        de_cnt    = 0;
    endtask

    function automatic logic vs_of(input int line, input int h);
        return ((line == 0) && (h >= HS_W)) || (line == 1) || ((line == 2) && (h < HS_W));
    endfunction

    // One input sample; outputs are observed 1 ns after the edge that took it.
    task automatic tick(input logic hs, input logic vs, input logic [11:0] rgb);
        vga_hs     = hs;
        vga_vs     = vs;
        pixel_data = rgb;
        @(posedge sys_clk);
        #1;
        if (lock_err) begin
            err_cnt++;
            err_samp = samp;
        end
        if (frame_start) begin
            fs_cnt++;
            fs_samp = samp;
        end
        if (pix_de) de_cnt++;
        if (locked && (lock_samp < 0)) lock_samp = samp;
        samp++;
    endtask

    task automatic run_line(input int line, input int len, input int h0, input int h1, input bit chk);
        logic [11:0] rgb;
        int          idx;
        for (int h = h0; (h < len) && (h < h1); h++) begin
            rgb = 12'hFFF;
            idx = -1;
            for (int k = 0; k < NV; k++) begin
                if (chk && (tbl[k].line == line) && (tbl[k].h == h)) idx = k;
            end
            if (idx >= 0) rgb = tbl[idx].rgb;
            tick(h < HS_W, vs_of(line, h), rgb);
            if (idx >= 0) begin
                check($sformatf("pix_de[v%0d]", idx), int'(pix_de), tbl[idx].exp_de);
                check($sformatf("pix_x[v%0d]", idx), int'(pix_x), tbl[idx].exp_x);
                check($sformatf("pix_y[v%0d]", idx), int'(pix_y), tbl[idx].exp_y);
                check($sformatf("pix_rgb[v%0d]", idx), int'(pix_rgb), tbl[idx].exp_rgb);
            end
        end
    endtask

    task automatic run_frame(input int nlines, input int stretch, input bit chk);
        for (int l = 0; l < nlines; l++) begin
            run_line(l, (l == stretch) ? HT + 1 : HT, 0, HT + 1, chk);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " locked"}, int'(locked), 0);
        check({tag, " lock_err"}, int'(lock_err), 0);
        check({tag, " frame_start"}, int'(frame_start), 0);
        check({tag, " pix_de"}, int'(pix_de), 0);
        check({tag, " pix_x"}, int'(pix_x), 0);
        check({tag, " pix_y"}, int'(pix_y), 0);
        check({tag, " pix_rgb"}, int'(pix_rgb), 0);
        check({tag, " line_len"}, int'(line_len), 0);
        check({tag, " frame_lines"}, int'(frame_lines), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        // line, h, rgb in, de, x, y, rgb out
        tbl[0] = '{3, 8,  12'hF00, 1, 0,  0, 12'hF00};
        tbl[1] = '{3, 7,  12'h0AB, 0, 0,  0, 12'h000};
        tbl[2] = '{8, 23, 12'h123, 1, 15, 5, 12'h123};
        tbl[3] = '{8, 24, 12'h456, 0, 0,  0, 12'h000};
        tbl[4] = '{2, 10, 12'h777, 0, 0,  0, 12'h000};
        tbl[5] = '{9, 10, 12'h777, 0, 0,  0, 12'h000};
        tbl[6] = '{5, 12, 12'hABC, 1, 4,  2, 12'hABC};
        tbl[7] = '{6, 20, 12'h0F0, 1, 12, 3, 12'h0F0};

        rst_n      = 1'b0;
        vga_hs     = 1'b0;
        vga_vs     = 1'b0;
        pixel_data = 12'h000;
        clear_stats();
        repeat (3) @(posedge sys_clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Initial acquisition: vs rises at h=HS_W of line 0 in every frame.
        clear_stats();
        run_frame(VT, -1, 1'b0);
        run_frame(VT, -1, 1'b0);
        run_frame(VT, -1, 1'b0);
        check("lock sample", lock_samp, 2 * HT * VT + HS_W);
        check("locked after acq", int'(locked), 1);
        check("line_len", int'(line_len), HT);
        check("frame_lines", int'(frame_lines), VT);
        check("lock_err during acq", err_cnt, 0);
        check("frame_start during acq", fs_cnt, 0);

        // Locked frame with table-driven pixel checks.
        clear_stats();
        run_frame(VT, -1, 1'b1);
        check("frame_start count", fs_cnt, 1);
        check("frame_start sample", fs_samp, HS_W);
        check("pix_de count", de_cnt, HA * VA);
        check("lock_err locked frame", err_cnt, 0);

        // One line stretched by a clock drops lock at the next hs rise.
        clear_stats();
        for (int l = 0; l < 6; l++) run_line(l, (l == 5) ? HT + 1 : HT, 0, HT + 1, 1'b0);
        run_line(6, HT, 0, 1, 1'b0);
        check("stretch line_len", int'(line_len), HT + 1);
        check("stretch lock_err count", err_cnt, 1);
        check("stretch lock_err sample", err_samp, 5 * HT + HT + 1);
        check("stretch locked", int'(locked), 0);
        run_line(6, HT, 1, HT, 1'b0);
        for (int l = 7; l < VT; l++) run_line(l, HT, 0, HT, 1'b0);
        run_frame(VT, -1, 1'b0);
        run_frame(VT, -1, 1'b0);
        check("stretch relock early", int'(locked), 0);
        run_frame(VT, -1, 1'b0);
        check("stretch relock", int'(locked), 1);
        check("stretch lock_err total", err_cnt, 1);

        // hs held low: lock drops exactly when h saturates at 2047.
        clear_stats();
        repeat (2100) tick(1'b0, 1'b0, 12'h0F0);
        check("timeout lock_err count", err_cnt, 1);
        check("timeout lock_err sample", err_samp, 2047 - HT);
        check("timeout locked", int'(locked), 0);

        // Reacquire, with a short frame while VERIFY holds one good frame.
        clear_stats();
        run_frame(VT, -1, 1'b0);
        run_frame(VT - 1, -1, 1'b0);
        samp = 0;
        run_frame(VT, -1, 1'b0);
        check("short frame_lines", int'(frame_lines), VT - 1);
        check("short lock_err count", err_cnt, 1);
        check("short lock_err sample", err_samp, HS_W);
        check("short locked", int'(locked), 0);
        run_frame(VT, -1, 1'b0);
        check("short good_cnt cleared", int'(locked), 0);
        check("no pix_de before relock", de_cnt, 0);
        run_frame(VT, -1, 1'b0);
        check("short relock", int'(locked), 1);
        check("short relock frame_lines", int'(frame_lines), VT);

        // Asynchronous reset in the middle of an active line.
        clear_stats();
        for (int l = 0; l < 4; l++) run_line(l, HT, 0, HT, 1'b0);
        run_line(4, HT, 0, 13, 1'b0);
        check("pre-reset pix_de", int'(pix_de), 1);
        check("pre-reset pix_x", int'(pix_x), 12 - HAS);
        rst_n = 1'b0;
        #2;
        check_all_zero("async reset");
        @(posedge sys_clk);
        #1;
        rst_n = 1'b1;
        clear_stats();
        run_frame(VT, -1, 1'b0);
        run_frame(VT, -1, 1'b0);
        check("post-reset not locked", int'(locked), 0);
        run_frame(VT, -1, 1'b0);
        check("post-reset lock sample", lock_samp, 2 * HT * VT + HS_W);
        check("post-reset locked", int'(locked), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
